// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of push, pop, occupancy and RAM-side signals for the RAM-backed FIFO controller.
// The slave modport is the controller's view; master is the surrounding producer/consumer/RAM.
interface ram_fifo_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  in_valid, in_data, out_ready, ram_dout,
    output in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_din
  );

  modport master (
    output in_valid, in_data, out_ready, ram_dout,
    input  in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller turning a 1-cycle-latency single-port RAM into a circular buffer
// with one registered output word. Reads take priority over writes for the single RAM port.
module ram_fifo_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    bus
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic          rd_go_s;
  logic          wr_go_s;
  logic          in_ready_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  // Port arbitration: a pending read wins, so in_ready never looks at in_valid.
  always_comb begin
    rd_go_s    = 1'b0;
    in_ready_s = 1'b0;
    wr_go_s    = 1'b0;
    if (count_r != {(AW+1){1'b0}} &&
        (state_r == IDLE || (state_r == HOLD && bus.out_ready))) begin
      rd_go_s = 1'b1;
    end else begin
      rd_go_s = 1'b0;
    end
    in_ready_s = !rst && (count_r != FULL_CNT) && !rd_go_s;
    wr_go_s    = bus.in_valid && in_ready_s;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.ram_we    = wr_go_s;
  assign bus.ram_addr  = wr_go_s ? wr_ptr_r : rd_ptr_r;
  assign bus.ram_din   = bus.in_data;
  assign bus.count     = count_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // Output FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_go_s) state_next_s = FETCH;
        else         state_next_s = IDLE;
      end
      FETCH: state_next_s = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          if (count_r != {(AW+1){1'b0}}) state_next_s = FETCH;
          else                           state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Pointers, occupancy, FSM state and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (rd_go_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        count_r  <= count_r - (AW+1)'(1);
      end else if (wr_go_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
        count_r  <= count_r + (AW+1)'(1);
      end else begin
        count_r  <= count_r;
      end
      case (state_r)
        FETCH: begin
          out_data_r  <= bus.ram_dout;
          out_valid_r <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
          else               out_valid_r <= 1'b1;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
